// File: rtl/rv_data_mem.sv
// rv_data_mem: byte-addressable RV32I data memory with registered 1-cycle loads,
// same-edge byte-lane stores and an error flag for misaligned/unsupported accesses.
module rv_data_mem #(
  parameter int ADDR_W = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [2:0]  memop,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        err
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] word_idx_s;
  logic [1:0]        lane_s;
  logic [31:0]       rword_s;
  logic [7:0]        rbyte_s;
  logic [15:0]       rhalf_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       ldata_s;
  logic              err_s;
  logic              unused_s;

  // Address bits above the word index are ignored, so the memory aliases.
  assign word_idx_s = addr[ADDR_W+1:2];
  assign lane_s     = addr[1:0];
  assign unused_s   = ^addr[31:ADDR_W+2];
  assign rword_s    = mem_r[word_idx_s];
  assign rbyte_s    = rword_s[{lane_s, 3'b000} +: 8];
  assign rhalf_s    = addr[1] ? rword_s[31:16] : rword_s[15:0];

  // Access decode: lane enables, replicated store data, extended load data, error.
  always_comb begin
    err_s   = 1'b0;
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    ldata_s = 32'h0000_0000;
    case (memop)
      3'b000, 3'b100: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{datain[7:0]}};
        if (memop[2]) begin
          ldata_s = {24'h00_0000, rbyte_s};
        end else begin
          ldata_s = {{24{rbyte_s[7]}}, rbyte_s};
        end
      end
      3'b001, 3'b101: begin
        if (addr[0]) begin
          err_s = 1'b1;
        end else begin
          be_s    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{datain[15:0]}};
          if (memop[2]) begin
            ldata_s = {16'h0000, rhalf_s};
          end else begin
            ldata_s = {{16{rhalf_s[15]}}, rhalf_s};
          end
        end
      end
      3'b010: begin
        if (lane_s != 2'b00) begin
          err_s = 1'b1;
        end else begin
          be_s    = 4'b1111;
          wdata_s = datain;
          ldata_s = rword_s;
        end
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  // Lane-masked store; errors leave be_s clear, and reset low blocks writes.
  always_ff @(posedge clock) begin
    if (reset && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Registered load result and error flag; stores and errors return zero data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataout <= 32'h0000_0000;
      err     <= 1'b0;
    end else begin
      err     <= err_s;
      dataout <= (we || err_s) ? 32'h0000_0000 : ldata_s;
    end
  end

endmodule

// File: tb/tb_rv_data_mem.sv
// Directed bench for rv_data_mem: a byte-array model checked every cycle,
// plus literal expectations on each directed access.
module tb_rv_data_mem;

  localparam int unsigned SPAN_MASK = (32'd1 << (15 + 2)) - 32'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] datain = 32'h0;
  logic [2:0]  memop = 3'b000;
  logic        we = 1'b0;
  logic [31:0] dataout;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mdl [int unsigned];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_dout = 32'h0;
  logic        exp_err = 1'b0;

  rv_data_mem #(.ADDR_W(15)) dut (
    .clock(clock), .reset(reset), .addr(addr), .datain(datain),
    .memop(memop), .we(we), .dataout(dataout), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void model_access(input logic w, input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd, output logic e);
    int unsigned size;
    int unsigned base;
    logic [31:0] v;
    rd = 32'h0;
    e  = 1'b0;
    case (op)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (a % size) != 0) begin
      e = 1'b1;
      return;
    end
    base = a & SPAN_MASK;
    if (w) begin
      for (int i = 0; i < int'(size); i++) mdl[base + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(size); i++)
        v = v | ({24'h0, (mdl.exists(base + i) ? mdl[base + i] : 8'h00)} << (8 * i));
      if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  // One access: drive at negedge, model at the sampling edge, literal check at next negedge.
  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] lit, input logic lit_err, input string name);
    logic [31:0] rd;
    logic        e;
    we = w; memop = op; addr = a; datain = d;
    @(posedge clock);
    model_access(w, op, a, d, rd, e);
    exp_dout  = rd;
    exp_err   = e;
    exp_valid = 1'b1;
    @(negedge clock);
    check({name, "_model"}, exp_dout, lit);
    check(name, dataout, lit);
    check({name, "_err"}, {31'b0, err}, {31'b0, lit_err});
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (exp_valid) begin
      check("cyc_dataout", dataout, exp_dout);
      check("cyc_err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_dataout", dataout, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    reset = 1'b1;

    access(1'b1, 3'b010, 32'h100, 32'h8765_4321, 32'h0, 1'b0, "st_w");
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h8765_4321, 1'b0, "ld_w");
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_0043, 1'b0, "ld_b101");
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF87, 1'b0, "ld_b103");
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0087, 1'b0, "ld_bu103");
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8765, 1'b0, "ld_h102");
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_8765, 1'b0, "ld_hu102");

    access(1'b1, 3'b010, 32'h101, 32'hDEAD_BEEF, 32'h0, 1'b1, "st_w_mis");
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h8765_4321, 1'b0, "ld_w_unch");

    access(1'b1, 3'b000, 32'h100, 32'hFFFF_FFAA, 32'h0, 1'b0, "st_b");
    access(1'b1, 3'b001, 32'h102, 32'hABCD_1234, 32'h0, 1'b0, "st_h");
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_43AA, 1'b0, "ld_w_lanes");

    access(1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1'b1, "ld_h_mis");
    access(1'b0, 3'b101, 32'h101, 32'h0, 32'h0, 1'b1, "ld_hu_mis");
    access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, "ld_op011");
    access(1'b1, 3'b110, 32'h100, 32'h5555_5555, 32'h0, 1'b1, "st_op110");
    access(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, "ld_op111");
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_43AA, 1'b0, "ld_w_after_ill");

    access(1'b1, 3'b010, 32'h0002_0100, 32'h0000_CAFE, 32'h0, 1'b0, "st_wrap");
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h0000_CAFE, 1'b0, "ld_wrap");
    access(1'b0, 3'b010, 32'hFFFE_0100, 32'h0, 32'h0000_CAFE, 1'b0, "ld_wrap_hi");

    access(1'b1, 3'b010, 32'h200, 32'h1122_3344, 32'h0, 1'b0, "st_w200");
    access(1'b0, 3'b000, 32'h203, 32'h0, 32'h0000_0011, 1'b0, "ld_b203_b2b");
    access(1'b1, 3'b100, 32'h201, 32'h0000_0077, 32'h0, 1'b0, "st_bu201");
    access(1'b0, 3'b010, 32'h200, 32'h0, 32'h1122_7744, 1'b0, "ld_w200");
    access(1'b0, 3'b001, 32'h200, 32'h0, 32'h0000_7744, 1'b0, "ld_h200");

    // Asynchronous reset between edges, with a store held on the bus.
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h0000_CAFE, 1'b0, "ld_pre_rst");
    #2;
    exp_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_async_dataout", dataout, 32'h0);
    check("rst_async_err", {31'b0, err}, 32'h0);
    we = 1'b1; memop = 3'b010; addr = 32'h100; datain = 32'hBAD0_BAD0;
    repeat (2) @(negedge clock);
    check("rst_hold_dataout", dataout, 32'h0);
    check("rst_hold_err", {31'b0, err}, 32'h0);
    reset = 1'b1;
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h0000_CAFE, 1'b0, "ld_post_rst");
    access(1'b0, 3'b010, 32'h200, 32'h0, 32'h1122_7744, 1'b0, "ld_post_rst200");

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
